// File: rtl/parity_pkg.sv
// ----------------------------------------------------------------------------
// parity_pkg
// Shared types and helpers for the parity stream unit.
//   parity_mode_e : even / odd parity selection
//   parity_op_e   : generate / check operation
//   lane_parity() : parity bit of a (zero-extended) lane, optionally inverted
//                   for odd parity
// ----------------------------------------------------------------------------
package parity_pkg;

    typedef enum logic {PAR_EVEN, PAR_ODD} parity_mode_e;
    typedef enum logic {PAR_GEN,  PAR_CHK} parity_op_e;

    // Widest lane the helper accepts; narrower lanes are zero-extended,
    // which does not change the XOR reduction.
    localparam int LANE_MAX_W = 64;

    function automatic logic lane_parity(input logic [LANE_MAX_W-1:0] data,
                                         input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_stream_unit_if.sv
// ----------------------------------------------------------------------------
// parity_stream_unit_if
// Bundles the input and output valid/ready streams of the parity stream unit.
//   s_valid/s_ready/s_data/s_par        : input beat (data + received parity)
//   m_valid/m_ready/m_data/m_par/m_err  : output beat (data + parity + errors)
// Modports:
//   slave  : the parity unit itself (consumes s_*, produces m_*)
//   master : the environment around it (produces s_*, consumes m_*)
// ----------------------------------------------------------------------------
interface parity_stream_unit_if #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 8
);
    localparam int NLANES = DATA_W / LANE_W;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [NLANES-1:0] s_par;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [NLANES-1:0] m_par;
    logic [NLANES-1:0] m_err;

    modport slave (
        input  s_valid, s_data, s_par, m_ready,
        output s_ready, m_valid, m_data, m_par, m_err
    );

    modport master (
        output s_valid, s_data, s_par, m_ready,
        input  s_ready, m_valid, m_data, m_par, m_err
    );
endinterface

// File: rtl/parity_lane_calc.sv
// ----------------------------------------------------------------------------
// parity_lane_calc
// Combinational parity for one lane.
//   lane_data : LANE_W data bits of this lane
//   mode      : PAR_EVEN / PAR_ODD
//   op        : PAR_GEN / PAR_CHK
//   rx_par    : received parity bit (only meaningful for PAR_CHK)
//   par       : computed parity bit
//   err       : computed parity differs from rx_par (always 0 for PAR_GEN)
// ----------------------------------------------------------------------------
module parity_lane_calc
    import parity_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0] lane_data,
    input  parity_mode_e      mode,
    input  parity_op_e        op,
    input  logic              rx_par,
    output logic              par,
    output logic              err
);

    if (LANE_W < 1 || LANE_W > LANE_MAX_W) begin : g_bad_lane_w
        $error("parity_lane_calc: LANE_W must be in 1..%0d", LANE_MAX_W);
    end

    assign par = lane_parity(LANE_MAX_W'(lane_data), mode == PAR_ODD);
    assign err = (op == PAR_CHK) && (par != rx_par);

endmodule

// File: rtl/parity_stream_unit.sv
// ----------------------------------------------------------------------------
// parity_stream_unit
// Streaming multi-lane parity generator / checker with one output register
// stage and sticky error status.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   cfg_odd     : 0 even / 1 odd parity, sampled per accepted beat
//   cfg_check   : 0 generate / 1 check, sampled per accepted beat
//   err_clr     : synchronous clear of err_sticky (and err_cnt)
//   bus         : parity_stream_unit_if.slave (s_* input stream, m_* output)
//   err_sticky  : set by any accepted beat with a lane mismatch
//   err_cnt     : saturating count of accepted error beats
//                 (present only when PARITY_ERR_CNT_EN is defined)
// Optional feature macro: PARITY_ERR_CNT_EN
// ----------------------------------------------------------------------------
module parity_stream_unit
    import parity_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANE_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_odd,
    input  logic                 cfg_check,
    input  logic                 err_clr,
    parity_stream_unit_if.slave  bus,
    output logic                 err_sticky
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]     err_cnt
`endif
);

    localparam int NLANES = DATA_W / LANE_W;

    if (LANE_W < 1 || (DATA_W % LANE_W) != 0) begin : g_bad_data_w
        $error("parity_stream_unit: DATA_W (%0d) must be a multiple of LANE_W (%0d)",
               DATA_W, LANE_W);
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("parity_stream_unit: CNT_W must be at least 1");
    end

    // ------------------------------------------------------------------
    // Per-lane parity / mismatch of the beat currently on the input
    // ------------------------------------------------------------------
    parity_mode_e      mode;
    parity_op_e        op;
    logic [NLANES-1:0] par_next;
    logic [NLANES-1:0] err_next;

    assign mode = cfg_odd   ? PAR_ODD : PAR_EVEN;
    assign op   = cfg_check ? PAR_CHK : PAR_GEN;

    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
        parity_lane_calc #(
            .LANE_W (LANE_W)
        ) u_lane (
            .lane_data (bus.s_data[gi*LANE_W +: LANE_W]),
            .mode      (mode),
            .op        (op),
            .rx_par    (bus.s_par[gi]),
            .par       (par_next[gi]),
            .err       (err_next[gi])
        );
    end

    // ------------------------------------------------------------------
    // Output stage and status registers
    // ------------------------------------------------------------------
    logic              m_valid_q,    m_valid_d;
    logic [DATA_W-1:0] m_data_q,     m_data_d;
    logic [NLANES-1:0] m_par_q,      m_par_d;
    logic [NLANES-1:0] m_err_q,      m_err_d;
    logic              err_sticky_q, err_sticky_d;
    logic              s_ready;
    logic              accept;
    logic              err_beat;

    // The output slot is free when empty or being drained this cycle.
    assign s_ready  = !m_valid_q || bus.m_ready;
    assign accept   = bus.s_valid && s_ready;
    assign err_beat = accept && (|err_next);

    always_comb begin
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_par_d      = m_par_q;
        m_err_d      = m_err_q;
        err_sticky_d = err_sticky_q;

        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = bus.s_data;
            m_par_d   = par_next;
            m_err_d   = err_next;
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end

        // Clear first so that a same-cycle error beat wins.
        if (err_clr) begin
            err_sticky_d = 1'b0;
        end
        if (err_beat) begin
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_par_q      <= '0;
            m_err_q      <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_par_q      <= m_par_d;
            m_err_q      <= m_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_par   = m_par_q;
    assign bus.m_err   = m_err_q;
    assign err_sticky  = err_sticky_q;

`ifdef PARITY_ERR_CNT_EN
    // ------------------------------------------------------------------
    // Saturating error-beat counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            // A clear coinciding with an error beat leaves that beat counted.
            err_cnt_d = err_beat ? CNT_W'(1) : '0;
        end else if (err_beat && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_stream_unit.sv
// ----------------------------------------------------------------------------
// tb_parity_stream_unit
// Directed and randomized stimulus for parity_stream_unit (DATA_W=16,
// LANE_W=8, CNT_W=8) with a queue-based reference of expected output beats.
// Build with PARITY_ERR_CNT_EN defined to also exercise err_cnt.
// ----------------------------------------------------------------------------
module tb_parity_stream_unit;

    localparam int DATA_W = 16;
    localparam int LANE_W = 8;
    localparam int NLANES = DATA_W / LANE_W;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [NLANES-1:0] par;
        logic [NLANES-1:0] err;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic cfg_odd;
    logic cfg_check;
    logic err_clr;
    logic err_sticky;
`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;
`endif

    parity_stream_unit_if #(.DATA_W(DATA_W), .LANE_W(LANE_W)) bus ();

    parity_stream_unit #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_odd    (cfg_odd),
        .cfg_check  (cfg_check),
        .err_clr    (err_clr),
        .bus        (bus),
        .err_sticky (err_sticky)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t exp_q[$];
    bit    sticky_m = 1'b0;
    int    cnt_m = 0;
    bit    acc_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected beat from the parity rules: count ones in each lane.
    function automatic beat_t model(input logic [DATA_W-1:0] d, input bit odd,
                                    input bit chk, input logic [NLANES-1:0] rx);
        beat_t b;
        b.data = d;
        for (int l = 0; l < NLANES; l++) begin
            logic [LANE_W-1:0] lane;
            lane = d[l*LANE_W +: LANE_W];
            b.par[l] = (($countones(lane) % 2) == 1) ? ~odd : odd;
            b.err[l] = chk && (b.par[l] != rx[l]);
        end
        return b;
    endfunction

    // One clock cycle: observe handshakes before the edge, update the
    // reference, then check registered state just after the edge.
    task automatic tick();
        bit    acc, outb;
        beat_t e;
        @(negedge clk);
        acc  = bus.s_valid && bus.s_ready;
        outb = bus.m_valid && bus.m_ready;
        check("s_ready", 32'(bus.s_ready), 32'(!bus.m_valid || bus.m_ready));
        if (outb) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("m_data", 32'(bus.m_data), 32'(e.data));
                check("m_par",  32'(bus.m_par),  32'(e.par));
                check("m_err",  32'(bus.m_err),  32'(e.err));
            end
        end
        if (err_clr) begin
            sticky_m = 1'b0;
            cnt_m    = 0;
        end
        if (acc) begin
            e = model(bus.s_data, cfg_odd, cfg_check, bus.s_par);
            exp_q.push_back(e);
            if (e.err != '0) begin
                sticky_m = 1'b1;
                if (cnt_m < CNT_MAX) cnt_m++;
            end
        end
        @(posedge clk);
        #1;
        check("m_valid", 32'(bus.m_valid), 32'(exp_q.size() != 0));
        check("err_sticky", 32'(err_sticky), 32'(sticky_m));
`ifdef PARITY_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'(cnt_m));
`endif
        acc_last = acc;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic odd,
                         input logic chk, input logic [NLANES-1:0] rx, input logic rdy);
        bus.s_valid = v;
        bus.s_data  = d;
        cfg_odd     = odd;
        cfg_check   = chk;
        bus.s_par   = rx;
        bus.m_ready = rdy;
    endtask

    initial begin
        beat_t b;
        logic [DATA_W-1:0] held;

        rst_n = 1'b0;
        err_clr = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

        // Reset state
        #12;
        check("rst_m_valid", 32'(bus.m_valid), 32'(0));
        check("rst_m_data",  32'(bus.m_data),  32'(0));
        check("rst_m_par",   32'(bus.m_par),   32'(0));
        check("rst_m_err",   32'(bus.m_err),   32'(0));
        check("rst_sticky",  32'(err_sticky),  32'(0));
`ifdef PARITY_ERR_CNT_EN
        check("rst_err_cnt", 32'(err_cnt),     32'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: generate, even parity
        drive(1'b1, 16'hE0AA, 1'b0, 1'b0, 2'b00, 1'b1);
        tick();
        check("t1_m_valid", 32'(bus.m_valid), 32'(1));
        check("t1_m_par",   32'(bus.m_par),   32'(2'b10));
        check("t1_m_err",   32'(bus.m_err),   32'(2'b00));

        // 2: generate, odd parity; received parity ignored
        drive(1'b1, 16'hE0AA, 1'b1, 1'b0, 2'b11, 1'b1);
        tick();
        check("t2_m_par", 32'(bus.m_par), 32'(2'b01));
        check("t2_m_err", 32'(bus.m_err), 32'(2'b00));

        // 3: check, even parity, lane 0 mismatching
        drive(1'b1, 16'h00FF, 1'b0, 1'b1, 2'b01, 1'b1);
        tick();
        check("t3_m_par",  32'(bus.m_par), 32'(2'b00));
        check("t3_m_err",  32'(bus.m_err), 32'(2'b01));
        check("t3_sticky", 32'(err_sticky), 32'(1));
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        tick();

        // 4: back-pressure for 3 cycles with a continuous source
        drive(1'b1, 16'h1111, 1'b0, 1'b0, '0, 1'b0);
        tick();
        held = bus.m_data;
        bus.s_data = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            check("t4_s_ready", 32'(bus.s_ready), 32'(0));
            check("t4_m_data_stable", 32'(bus.m_data), 32'(held));
            tick();
        end
        bus.m_ready = 1'b1;
        for (int i = 3; i <= 6; i++) begin
            tick();
            bus.s_data = 16'(i * 16'h1111);
        end
        bus.s_valid = 1'b0;
        tick();
        tick();

        // 5: clear coinciding with an error beat, then counter saturation
        err_clr = 1'b1;
        tick();
        check("t5_cleared", 32'(err_sticky), 32'(0));
        b = model(16'hA5C3, 1'b0, 1'b1, 2'b00);
        drive(1'b1, 16'hA5C3, 1'b0, 1'b1, ~b.par, 1'b1);
        tick();
        err_clr = 1'b0;
        check("t5_sticky_set_wins", 32'(err_sticky), 32'(1));
`ifdef PARITY_ERR_CNT_EN
        check("t5_cnt_one", 32'(err_cnt), 32'(1));
`endif
        for (int i = 0; i < 300; i++) begin
            held = 16'($urandom);
            b = model(held, 1'b1, 1'b1, 2'b00);
            drive(1'b1, held, 1'b1, 1'b1, b.par ^ NLANES'($urandom_range(1, 3)), 1'b1);
            tick();
        end
`ifdef PARITY_ERR_CNT_EN
        check("t5_cnt_sat", 32'(err_cnt), 32'(CNT_MAX));
`endif

        // Randomized traffic with random back-pressure, modes and clears
        acc_last = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (acc_last || !bus.s_valid) begin
                bus.s_valid = 1'($urandom_range(0, 3) != 0);
                bus.s_data  = 16'($urandom);
                bus.s_par   = NLANES'($urandom);
                cfg_odd     = 1'($urandom);
                cfg_check   = 1'($urandom);
            end
            bus.m_ready = 1'($urandom_range(0, 2) != 0);
            err_clr     = 1'($urandom_range(0, 15) == 0);
            tick();
        end
        err_clr = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        tick();
        check("drained", 32'(exp_q.size()), 32'(0));

        // 6: asynchronous reset while a beat is held
        b = model(16'h00FF, 1'b0, 1'b1, 2'b11);
        drive(1'b1, 16'h00FF, 1'b0, 1'b1, 2'b11, 1'b0);
        tick();
        check("t6_m_valid_before", 32'(bus.m_valid), 32'(1));
        bus.s_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_m_valid", 32'(bus.m_valid), 32'(0));
        check("t6_sticky",  32'(err_sticky),  32'(0));
        check("t6_m_data",  32'(bus.m_data),  32'(0));
`ifdef PARITY_ERR_CNT_EN
        check("t6_err_cnt", 32'(err_cnt),     32'(0));
`endif
        exp_q.delete();
        sticky_m = 1'b0;
        cnt_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
